dti_upsizer: RTL and testbench
==============================

DTI_UPSIZER -- requirements
Module: dti_upsizer

Interface
REQ-001 SHALL have parameter DIN, default 16: payload width of one input word in bits, minimum 1.
REQ-002 SHALL have parameter RATIO, default 4: number of input words packed per output word, minimum 1; CNTW = $clog2(RATIO)+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, dti.consumer, data width DIN+1: data = {eot, payload[DIN-1:0]}, plus valid and ready.
REQ-006 SHALL have port dout, dti.producer, data width 1+CNTW+RATIO*DIN: data = {eot, cnt[CNTW-1:0], lanes[RATIO*DIN-1:0]}, plus valid and ready.

Function
REQ-007 SHALL pack consecutive accepted din payloads into lanes in arrival order; first word -> lane 0 (bits DIN-1:0), k-th word -> lane k.
REQ-008 SHALL treat a din transfer as din.valid & din.ready in the same cycle; dout transfer as dout.valid & dout.ready.
REQ-009 SHALL close a group when the accepted word fills lane RATIO-1, or when its eot bit is 1, whichever comes first.
REQ-010 SHALL, on group close, present the group on dout in the next cycle: dout.valid=1, cnt = number of words in group (1..RATIO), eot = eot bit of closing word, unfilled lanes = 0.
REQ-011 SHALL implement two states: FILL (collecting, dout.valid=0) and HOLD (group presented, dout.valid=1).
REQ-012 SHALL in FILL drive din.ready=1; accepting a non-closing word stays in FILL with lane index +1; accepting a closing word -> HOLD, lane index -> 0.
REQ-013 SHALL in HOLD drive din.ready = dout.ready (combinational); if dout.ready=0, hold dout.data and dout.valid unchanged and accept nothing.
REQ-014 SHALL in HOLD with dout.ready=1 and no din transfer -> FILL with all lanes cleared and lane index 0.
REQ-015 SHALL in HOLD with dout.ready=1 and a din transfer start the next group with that word in lane 0, other lanes cleared; if that word closes the group (eot=1 or RATIO=1), stay in HOLD with the new single-word group, else -> FILL with lane index 1.
REQ-016 SHALL sustain one din word per cycle when dout.ready stays 1; no bubble cycles between groups.
REQ-017 SHALL keep dout.data stable while dout.valid=1 and dout.ready=0.
REQ-018 SHALL never drop, duplicate or reorder payloads; cnt SHALL never be 0 while dout.valid=1.
REQ-019 SHALL ignore din.data when no din transfer occurs; an eot without a preceding partial group SHALL produce a cnt=1 group.
REQ-020 SHALL, for RATIO=1, close every accepted word (cnt=1, eot passed through).

Reset
REQ-021 SHALL on rst=1, without waiting for clk, force state FILL, lane index 0, all lanes 0, held eot 0, cnt 0, dout.valid=0.
REQ-022 SHALL drive din.ready=1 and dout.data=0 while and after reset until the first transfer.
REQ-023 SHALL discard any partial or held group when reset is asserted mid-operation; the first group after release starts in lane 0.

Verification
REQ-024 SHALL pass: RATIO=4, DIN=16, dout.ready=1, din words 0x0001..0x0004 eot=0 on 4 consecutive cycles -> next cycle dout.valid=1, lanes=0x0004_0003_0002_0001, cnt=4, eot=0, for exactly 1 cycle.
REQ-025 SHALL pass: RATIO=4, words 0x00AA, 0x00BB(eot=1) -> dout lanes=0x0000_0000_00BB_00AA, cnt=2, eot=1.
REQ-026 SHALL pass: group presented, dout.ready=0 for 5 cycles while din.valid=1 -> din.ready=0, dout.data constant; dout.ready=1 -> din word accepted same cycle into lane 0 of next group.
REQ-027 SHALL pass: 12 back-to-back words, dout.ready=1 -> 3 dout groups on 3 cycles spaced 4 apart, din.ready never 0.
REQ-028 SHALL pass: rst asserted asynchronously after 2 accepted words -> dout.valid=0 immediately; then 4 words 0x0011..0x0014 -> lanes=0x0014_0013_0012_0011, cnt=4.
REQ-029 SHALL pass: RATIO=1, words 0x0005(eot=0), 0x0006(eot=1), dout.ready=1 -> two groups {eot=0,cnt=1,0x0005} then {eot=1,cnt=1,0x0006} on consecutive cycles.

Source files
------------

// File: rtl/dti_upsizer_if.sv
// Valid/ready data transfer interface.
// Producer drives data/valid, consumer drives ready.
interface dti #(
  parameter int W = 1
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (
    output data,
    output valid,
    input  ready
  );

  modport consumer (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/dti_upsizer.sv
// Width upsizer: packs RATIO input words into one output word.
// A group closes when full or on an eot word, then is held on dout.
module dti_upsizer #(
  parameter int DIN   = 16,
  parameter int RATIO = 4
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  din,
  dti.producer  dout
);

  localparam int CNTW = $clog2(RATIO) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(RATIO - 1);
  localparam logic [CNTW-1:0] ONE = CNTW'(1);
  localparam bit SINGLE = (RATIO == 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        idx_q, idx_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   eot_q, eot_d;
  logic [RATIO*DIN-1:0]   lanes_q, lanes_d;

  logic [DIN-1:0]         pay;
  logic                   eot_in;
  logic                   din_xfer;

  assign pay      = din.data[DIN-1:0];
  assign eot_in   = din.data[DIN];
  assign din_xfer = din.valid & din.ready;

  assign din.ready  = (state_q == FILL) | dout.ready;
  assign dout.valid = (state_q == HOLD);
  assign dout.data  = {eot_q, cnt_q, lanes_q};

  // Next-state: collect words in FILL, present and restart in HOLD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    eot_d   = eot_q;
    lanes_d = lanes_q;
    unique case (state_q)
      FILL: begin
        if (din_xfer) begin
          for (int i = 0; i < RATIO; i++) begin
            if (idx_q == CNTW'(i)) begin
              lanes_d[i*DIN +: DIN] = pay;
            end
          end
          if (eot_in || idx_q == LAST) begin
            state_d = HOLD;
            cnt_d   = idx_q + ONE;
            eot_d   = eot_in;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      HOLD: begin
        if (dout.ready) begin
          lanes_d = '0;
          cnt_d   = '0;
          eot_d   = 1'b0;
          idx_d   = '0;
          state_d = FILL;
          if (din_xfer) begin
            lanes_d[DIN-1:0] = pay;
            if (eot_in || SINGLE) begin
              state_d = HOLD;
              cnt_d   = ONE;
              eot_d   = eot_in;
            end else begin
              idx_d = ONE;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register with asynchronous clear of any partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      eot_q   <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      eot_q   <= eot_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: tb/tb_dti_upsizer.sv
// Bench for dti_upsizer: queue model of groups plus directed cases
// for RATIO=4 and RATIO=1 instances.
module tb_dti_upsizer;

  logic clk;
  logic rst;

  dti #(.W(17)) din4 ();
  dti #(.W(68)) dout4 ();
  dti #(.W(17)) din1 ();
  dti #(.W(18)) dout1 ();

  dti_upsizer #(.DIN(16), .RATIO(4)) u4 (
    .clk  (clk),
    .rst  (rst),
    .din  (din4),
    .dout (dout4)
  );

  dti_upsizer #(.DIN(16), .RATIO(1)) u1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din1),
    .dout (dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Group model for the RATIO=4 instance.
  logic [67:0] exp_q[$];
  logic [15:0] cur[$];
  logic [67:0] prev_data;
  logic        prev_hold;
  logic [63:0] ln;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur.delete();
      prev_hold = 1'b0;
    end else begin
      chk("m_din_ready", 128'(din4.ready),
          128'(!(dout4.valid && !dout4.ready)));
      chk("m_valid", 128'(dout4.valid), 128'(exp_q.size() != 0));
      if (prev_hold) chk("m_stable", 128'(dout4.data), 128'(prev_data));
      if (dout4.valid && exp_q.size() != 0) begin
        chk("m_group", 128'(dout4.data), 128'(exp_q[0]));
        chk("m_cnt_nz", 128'(dout4.data[66:64] != 3'd0), 128'(1));
        if (dout4.ready) void'(exp_q.pop_front());
      end
      if (din4.valid && din4.ready) begin
        cur.push_back(din4.data[15:0]);
        if (din4.data[16] || cur.size() == 4) begin
          ln = '0;
          foreach (cur[k]) ln[k*16 +: 16] = cur[k];
          exp_q.push_back({din4.data[16], 3'(cur.size()), ln});
          cur.delete();
        end
      end
      prev_hold = dout4.valid && !dout4.ready;
      prev_data = dout4.data;
    end
  end

  logic [67:0] held;
  int          vpos[$];

  initial begin
    rst = 1'b1;
    din4.valid = 1'b0;
    din4.data = '0;
    dout4.ready = 1'b1;
    din1.valid = 1'b0;
    din1.data = '0;
    dout1.ready = 1'b1;
    #1;
    repeat (3) cyc();
    chk("rst_din_ready", 128'(din4.ready), 128'(1));
    chk("rst_valid", 128'(dout4.valid), 128'(0));
    chk("rst_data", 128'(dout4.data), 128'(0));
    rst = 1'b0;
    cyc();
    chk("idle_data", 128'(dout4.data), 128'(0));

    // Four full words, one cycle of valid.
    for (int i = 1; i <= 4; i++) begin
      din4.valid = 1'b1;
      din4.data = {1'b0, 16'(i)};
      if (i == 4) chk("full_pre_valid", 128'(dout4.valid), 128'(0));
      cyc();
    end
    din4.valid = 1'b0;
    chk("full_valid", 128'(dout4.valid), 128'(1));
    chk("full_data", 128'(dout4.data),
        128'({1'b0, 3'd4, 64'h0004_0003_0002_0001}));
    cyc();
    chk("full_one_cycle", 128'(dout4.valid), 128'(0));

    // Short group closed by eot.
    din4.valid = 1'b1;
    din4.data = {1'b0, 16'h00AA};
    cyc();
    din4.data = {1'b1, 16'h00BB};
    cyc();
    din4.valid = 1'b0;
    chk("eot_valid", 128'(dout4.valid), 128'(1));
    chk("eot_data", 128'(dout4.data),
        128'({1'b1, 3'd2, 64'h0000_0000_00BB_00AA}));
    cyc();

    // Back-pressure while a group is held.
    dout4.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din4.valid = 1'b1;
      din4.data = {1'b0, 16'(16'h21 + i)};
      cyc();
    end
    held = dout4.data;
    chk("bp_held", 128'(held),
        128'({1'b0, 3'd4, 64'h0024_0023_0022_0021}));
    din4.data = {1'b0, 16'h0055};
    for (int i = 0; i < 5; i++) begin
      chk("bp_din_ready", 128'(din4.ready), 128'(0));
      chk("bp_data", 128'(dout4.data), 128'(held));
      cyc();
    end
    dout4.ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(din4.ready), 128'(1));
    cyc();
    chk("bp_lane0_valid", 128'(dout4.valid), 128'(0));
    chk("bp_lane0", 128'(dout4.data[15:0]), 128'(16'h0055));
    din4.data = {1'b1, 16'h0056};
    cyc();
    din4.valid = 1'b0;
    chk("bp_next", 128'(dout4.data),
        128'({1'b1, 3'd2, 64'h0000_0000_0056_0055}));
    cyc();

    // Twelve back-to-back words.
    for (int i = 0; i < 12; i++) begin
      din4.valid = 1'b1;
      din4.data = {1'b0, 16'(16'h100 + i)};
      chk("b2b_din_ready", 128'(din4.ready), 128'(1));
      cyc();
      if (dout4.valid) vpos.push_back(i);
    end
    din4.valid = 1'b0;
    chk("b2b_groups", 128'(vpos.size()), 128'(3));
    if (vpos.size() == 3) begin
      chk("b2b_gap1", 128'(vpos[1] - vpos[0]), 128'(4));
      chk("b2b_gap2", 128'(vpos[2] - vpos[1]), 128'(4));
    end
    chk("b2b_last", 128'(dout4.data),
        128'({1'b0, 3'd4, 64'h010B_010A_0109_0108}));
    cyc();

    // Asynchronous reset with a partial group.
    din4.valid = 1'b1;
    din4.data = {1'b0, 16'h00E1};
    cyc();
    din4.data = {1'b0, 16'h00E2};
    cyc();
    din4.valid = 1'b0;
    chk("pre_rst_partial", 128'(dout4.data[31:0]), 128'(32'h00E2_00E1));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(dout4.valid), 128'(0));
    chk("arst_data", 128'(dout4.data), 128'(0));
    chk("arst_din_ready", 128'(din4.ready), 128'(1));
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din4.valid = 1'b1;
      din4.data = {1'b0, 16'(16'h11 + i)};
      cyc();
    end
    din4.valid = 1'b0;
    chk("post_rst", 128'(dout4.data),
        128'({1'b0, 3'd4, 64'h0014_0013_0012_0011}));
    cyc();
    chk("model_drained", 128'(exp_q.size()), 128'(0));

    // RATIO=1: every word is its own group.
    din1.valid = 1'b1;
    din1.data = {1'b0, 16'h0005};
    cyc();
    chk("r1_g0_valid", 128'(dout1.valid), 128'(1));
    chk("r1_g0", 128'(dout1.data), 128'({1'b0, 1'b1, 16'h0005}));
    din1.data = {1'b1, 16'h0006};
    cyc();
    din1.valid = 1'b0;
    chk("r1_g1_valid", 128'(dout1.valid), 128'(1));
    chk("r1_g1", 128'(dout1.data), 128'({1'b1, 1'b1, 16'h0006}));
    cyc();
    chk("r1_idle", 128'(dout1.valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
